fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Single-clock write-side arbiter sharing one asyn_fifo write port among NUM_REQ requesters.
- Grants bursts round-robin and muxes the owner's data onto wr_en/wr_data.
- Applies FIFO back-pressure: stalls on full and blocks new bursts on almost_full.
- Sits in the wr_clk domain directly in front of the FIFO.

Parameters:
- DATA_WIDTH, 16, width of each requester word and of fifo_wr_data.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- BURST_LEN, 8, maximum words per grant; legal range 1..255.

Ports:
- wr_clk  input  1  write-domain clock.
- wr_rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester accept; a word transfers when valid and ready are both high.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- fifo_full  input  1  FIFO full flag.
- fifo_almost_full  input  1  FIFO almost_full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- busy  output  1  high while in the BURST state.

Behaviour:
- Reset (asynchronous, wr_rst_n low):
  - state = IDLE; grant = 0; beat_cnt = 0; rr_ptr = 0; busy = 0.
  - req_ready, fifo_wr_en and fifo_wr_data are combinational and therefore all 0 during reset.
- Counter widths:
  - beat_cnt is 8 bits and counts accepted beats in the current burst.
  - rr_ptr is clog2(NUM_REQ) bits and holds the highest-priority index; it wraps modulo NUM_REQ.
- IDLE state:
  - If any req_valid is high and fifo_almost_full = 0: pick the first valid requester scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - Register the pick one-hot into grant, clear beat_cnt, go to BURST. Grant appears on the clock edge after the request is seen, so request-to-grant latency is 1 cycle.
  - If fifo_almost_full = 1, stay in IDLE with grant = 0.
- BURST state, owner g:
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full (combinational).
  - fifo_wr_data = req_data word g whenever busy, else 0.
  - A beat counts only when fifo_wr_en = 1; beat_cnt increments by 1.
- Burst end: return to IDLE on the next edge when any of the following holds.
  - (a) The accepted beat is number BURST_LEN.
  - (b) req_valid[g] = 0; no transfer happens that cycle.
  - (c) fifo_almost_full = 1 on a cycle with an accepted beat; that beat is still written.
  - On any exit: grant → 0 and rr_ptr → (g+1) mod NUM_REQ.
- Minimum gap: IDLE lasts at least 1 cycle between bursts, so fifo_wr_en is low for at least 1 cycle between consecutive bursts.
- fifo_full during BURST:
  - Stall: wr_en = 0, ready = 0, beat_cnt held.
  - The burst is not terminated while req_valid[g] stays high.
- Simultaneous conditions:
  - BURST_LEN reached together with almost_full: single exit, no double pointer advance.
  - fifo_full with req_valid[g] low: exit via (b).
- Invariants:
  - Never more than one grant bit set.
  - Never a write while fifo_full = 1.
  - Words from one requester are written in presentation order.
- Reset mid-burst: immediate return to reset values. The in-flight beat is not written, because wr_en drops combinationally with grant.

Test Plan:
- Reset, then req_valid = 4'b0001 held with continuous data 1,2,3,... → grant = 0001 one cycle later; exactly 8 writes (data 1..8); 1 idle cycle; next burst writes 9..16.
- req_valid = 4'b1111 held for 4 bursts (rr_ptr starts at 0) → grant sequence 0001, 0010, 0100, 1000, then back to 0001; each burst is 8 writes.
- Owner 2 bursting; fifo_full high for 3 cycles after beat 3 → wr_en low for those 3 cycles; beat_cnt stays 3; 5 more beats follow; 8 total written.
- Owner 0 bursting; fifo_almost_full rises at beat 4 → beat 4 written; grant = 0 next cycle; no new grant while almost_full stays 1; owner 1 granted 1 cycle after almost_full falls.
- Owner 1 drops req_valid after 2 beats → burst ends with 2 writes; next pending requester (index 2) granted after 1 idle cycle.
- wr_rst_n pulsed low mid-burst at beat 5 → grant, wr_en and busy go 0 immediately; after release, the first grant starts at requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter sharing one FIFO write port among NUM_REQ requesters.
// The arbiter grants bursts of up to BURST_LEN words in round-robin order and
// muxes the owner's words onto fifo_wr_en/fifo_wr_data.
// fifo_full stalls the current burst. fifo_almost_full ends the current burst
// and blocks the start of new ones.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 8
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_grant;
  logic [7:0]            r_beat_cnt;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_owner;

  logic                  w_busy;
  logic                  w_owner_valid;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic                  w_wr_en;
  logic                  w_pick_found;
  logic [PTR_W-1:0]      w_pick_idx;
  logic [PTR_W-1:0]      w_next_ptr;
  logic                  w_last_beat;

  assign w_busy      = (r_state == S_BURST);
  assign w_wr_en     = w_busy & w_owner_valid & ~fifo_full;
  assign w_last_beat = (r_beat_cnt == 8'(BURST_LEN - 1));
  assign w_next_ptr  = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  // Select the owner's valid bit and data word using the one-hot grant.
  always_comb begin
    // NOTE: every always_comb output gets a default first. Without it, a path
    // that leaves the output unassigned infers a latch.
    w_owner_valid = 1'b0;
    w_owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_owner_valid = req_valid[i];
        w_owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin pick. The first loop finds the lowest valid index overall.
  // The second loop replaces it with the lowest valid index at or after
  // rr_ptr, when such an index exists.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = PTR_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(r_rr_ptr))) begin
        w_pick_idx = PTR_W'(i);
      end
    end
  end

  // The FIFO-facing outputs are combinational. They drop as soon as the grant
  // clears, so a reset during a burst writes no partial beat.
  assign req_ready    = (w_busy & ~fifo_full) ? r_grant : '0;
  assign fifo_wr_en   = w_wr_en;
  assign fifo_wr_data = w_busy ? w_owner_data : '0;
  assign grant        = r_grant;
  assign busy         = w_busy;

  // Burst FSM: grant in IDLE, count beats in BURST, advance the pointer on exit.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the clock edge.
    if (!wr_rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_found && !fifo_almost_full) begin
            r_state    <= S_BURST;
            r_grant    <= NUM_REQ'(1) << w_pick_idx;
            r_owner    <= w_pick_idx;
            r_beat_cnt <= '0;
          end
        end
        S_BURST: begin
          if (!w_owner_valid) begin
            // The owner withdrew its request, so the burst ends with no transfer.
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
          end else if (w_wr_en) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            // Only one exit is taken, even when the last beat and
            // almost_full occur together.
            if (w_last_beat || fifo_almost_full) begin
              r_state  <= S_IDLE;
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
            end
          end
          // When fifo_full stalls a valid owner, every register holds its value.
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. A transaction-level reference model
// (owner index, beat count, round-robin pointer) predicts the outputs in every
// cycle. Directed scenarios are followed by a randomized phase.
module tb_fifo_wr_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int BL = 8;

  logic             wr_clk = 1'b0;
  logic             wr_rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    grant;
  logic             fifo_full;
  logic             fifo_almost_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             busy;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .wr_clk          (wr_clk),
    .wr_rst_n        (wr_rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .grant           (grant),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_wr_data    (fifo_wr_data),
    .busy            (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state. m_owner = -1 means idle.
  int m_owner = -1;
  int m_beats = 0;
  int m_rr    = 0;
  int seq[NR];

  int n_wr_obs = 0;
  int n_wr_exp = 0;
  logic [NR-1:0] prev_grant = '0;
  logic [NR-1:0] grant_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return DW'((i << 12) | (seq[i] & 12'hfff));
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_of(i);
  endtask

  // Compare all outputs at the negative edge, then advance the model across
  // the next rising edge.
  task automatic step();
    bit            m_busy;
    bit            exp_wr;
    bit            fin;
    logic [NR-1:0] exp_grant;
    logic [NR-1:0] exp_ready;
    logic [DW-1:0] exp_data;
    @(negedge wr_clk);
    m_busy    = (m_owner >= 0);
    exp_grant = m_busy ? (NR'(1) << m_owner) : '0;
    exp_ready = (m_busy && !fifo_full) ? exp_grant : '0;
    exp_wr    = m_busy && req_valid[m_owner] && !fifo_full;
    exp_data  = m_busy ? word_of(m_owner) : '0;
    check("grant",     64'(grant),        64'(exp_grant));
    check("busy",      64'(busy),         64'(m_busy));
    check("req_ready", 64'(req_ready),    64'(exp_ready));
    check("wr_en",     64'(fifo_wr_en),   64'(exp_wr));
    check("wr_data",   64'(fifo_wr_data), 64'(exp_data));
    if (fifo_wr_en) n_wr_obs++;
    if (exp_wr) n_wr_exp++;
    if (prev_grant == '0 && grant != '0) grant_log.push_back(grant);
    prev_grant = grant;
    if (!m_busy) begin
      if (req_valid != '0 && !fifo_almost_full) begin
        for (int k = NR - 1; k >= 0; k--)
          if (req_valid[(m_rr + k) % NR]) m_owner = (m_rr + k) % NR;
        m_beats = 0;
      end
    end else begin
      fin = 1'b0;
      if (!req_valid[m_owner]) fin = 1'b1;
      else if (exp_wr) begin
        seq[m_owner]++;
        m_beats++;
        if (m_beats == BL || fifo_almost_full) fin = 1'b1;
      end
      if (fin) begin
        m_rr    = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
    @(posedge wr_clk);
    #1;
    drive_data();
  endtask

  // Assert reset at the current time. Outputs must clear at once. Reset is
  // released at a negative edge with no requests pending.
  task automatic do_reset();
    wr_rst_n = 1'b0;
    #2;
    check("rst_grant", 64'(grant),      64'(0));
    check("rst_busy",  64'(busy),       64'(0));
    check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
    check("rst_ready", 64'(req_ready),  64'(0));
    m_owner = -1; m_beats = 0; m_rr = 0;
    req_valid = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
    prev_grant = '0;
    @(negedge wr_clk);
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic wait_beats(input int owner, input int beats, input string tag);
    int n;
    n = 0;
    while (!(m_owner == owner && m_beats == beats) && n < 40) begin
      step();
      n++;
    end
    check(tag, 64'(m_beats), 64'(beats));
  endtask

  int base;
  logic [NR-1:0] exp_seq[5];

  initial begin
    for (int i = 0; i < NR; i++) seq[i] = 1;
    wr_rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
    drive_data();
    #12;
    do_reset();

    // A single requester streams: two 8-beat bursts, one idle cycle between them.
    req_valid = 4'b0001;
    base = n_wr_obs;
    repeat (20) step();
    check("s1_writes", 64'(n_wr_obs - base), 64'(17));

    // All requesters valid: grants rotate 0, 1, 2, 3 and then back to 0.
    do_reset();
    grant_log.delete();
    req_valid = 4'b1111;
    repeat (40) step();
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    check("rr_count", 64'(grant_log.size() >= 5), 64'(1));
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) check($sformatf("rr_grant%0d", i), 64'(grant_log[i]), 64'(exp_seq[i]));

    // Owner 2 stalls for 3 cycles on fifo_full after beat 3. The burst still writes 8 words.
    do_reset();
    req_valid = 4'b0100;
    base = n_wr_obs;
    wait_beats(2, 3, "full_wait");
    fifo_full = 1'b1;
    repeat (3) step();
    fifo_full = 1'b0;
    repeat (6) step();
    check("full_writes", 64'(n_wr_obs - base), 64'(8));

    // almost_full rises during beat 4 of owner 0. Owner 1 is granted after almost_full falls.
    do_reset();
    req_valid = 4'b0011;
    wait_beats(0, 3, "af_wait");
    fifo_almost_full = 1'b1;
    repeat (4) step();
    fifo_almost_full = 1'b0;
    repeat (3) step();
    check("af_owner", 64'(m_owner), 64'(1));

    // Owner 1 withdraws its request after 2 beats. Requester 2 is granted next.
    do_reset();
    req_valid = 4'b0110;
    wait_beats(1, 2, "drop_wait");
    req_valid = 4'b0100;
    repeat (4) step();

    // Reset during a burst at beat 5. The first grant after release goes to requester 0.
    do_reset();
    req_valid = 4'b1111;
    repeat (2) step();
    wait_beats(0, 5, "mid_wait");
    repeat (3) step();
    wait_beats(1, 5, "mid_wait1");
    do_reset();
    req_valid = 4'b1111;
    repeat (3) step();
    check("post_rst_grant", 64'(grant), 64'(4'b0001));

    // Randomized traffic and back-pressure, with an occasional reset.
    for (int c = 0; c < 3000; c++) begin
      req_valid        = NR'($urandom);
      fifo_full        = ($urandom_range(0, 7) == 0);
      fifo_almost_full = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    check("total_writes", 64'(n_wr_obs), 64'(n_wr_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
